parity_frame_fsm: RTL and testbench

Parametrised streaming parity generator/checker that accumulates parity across a frame of WIDTH-bit words, succeeding the fixed 3-bit single-word parity FSM. It sits between a data source and a serial/link framer. Input uses a valid/ready handshake, and each frame ends after FRAME_LEN words or an early `in_last`. At frame end it presents registered even/odd parity bits with a one-cycle result strobe, and can optionally compare them against a received parity bit.

---
 rtl/parity_frame_fsm.sv | 73 +++++++
 tb/tb_parity_frame_fsm.sv | 137 +++++++++++++
 2 files changed

// File: rtl/parity_frame_fsm.sv
// parity_frame_fsm: streaming frame parity generator with optional received-parity check (PARITY_CHECK_EN)
module parity_frame_fsm #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4,
  parameter int CW        = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             in_last,
  output logic             par_valid,
  output logic             even,
  output logic             odd,
  output logic [CW-1:0]    frame_words
`ifdef PARITY_CHECK_EN
  ,
  input  logic             odd_sel,
  input  logic             exp_par,
  output logic             err
`endif
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_n;
  logic acc, acc_n, accept, fin;
  logic [CW-1:0] cnt, cnt_n;
  assign accept = in_valid & in_ready;
  assign acc_n  = acc ^ (^din);
  assign cnt_n  = cnt + CW'(1);
  assign fin    = in_last | (cnt_n == CW'(FRAME_LEN));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_comb
    state_n = state == DONE ? IDLE : accept ? (fin ? DONE : ACCUM) : state;
  always_comb begin
    in_ready  = state != DONE;
    par_valid = state == DONE;
  end
  // acc/cnt are cleared on the final word so IDLE always starts from zero
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc         <= 1'b0;
      cnt         <= '0;
      even        <= 1'b0;
      odd         <= 1'b0;
      frame_words <= '0;
    end else if (accept) begin
      if (fin) begin
        acc         <= 1'b0;
        cnt         <= '0;
        even        <= acc_n;
        odd         <= ~acc_n;
        frame_words <= cnt_n;
      end else begin
        acc <= acc_n;
        cnt <= cnt_n;
      end
    end
`ifdef PARITY_CHECK_EN
  logic sel_r, sel;
  assign sel = state == IDLE ? odd_sel : sel_r;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sel_r <= 1'b0;
      err   <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) sel_r <= odd_sel;
      if (fin) err <= (sel ? ~acc_n : acc_n) != exp_par;
    end
`endif
endmodule

// File: tb/tb_parity_frame_fsm.sv
// tb_parity_frame_fsm: directed scoreboard bench for parity_frame_fsm (WIDTH=8, FRAME_LEN=4)
module tb_parity_frame_fsm;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0;
  logic [7:0] din = 0;
  logic in_ready, par_valid, even, odd;
  logic [2:0] frame_words;
`ifdef PARITY_CHECK_EN
  logic odd_sel = 0, exp_par = 0, err;
`endif
  typedef struct packed {logic e; logic [2:0] fw; logic er;} res_t;
  res_t q[$];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  parity_frame_fsm #(.WIDTH(8), .FRAME_LEN(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .in_last(in_last), .par_valid(par_valid), .even(even), .odd(odd),
    .frame_words(frame_words)
`ifdef PARITY_CHECK_EN
    , .odd_sel(odd_sel), .exp_par(exp_par), .err(err)
`endif
  );
  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk1({tag, "_in_ready"}, in_ready, 1'b1);
    chk1({tag, "_par_valid"}, par_valid, 1'b0);
    chk1({tag, "_even"}, even, 1'b0);
    chk1({tag, "_odd"}, odd, 1'b0);
    chk3({tag, "_frame_words"}, frame_words, 3'd0);
  endtask
  task automatic send(input logic [7:0] d, input logic l);
    @(negedge clk);
    chk1("in_ready_send", in_ready, 1'b1);
    in_valid = 1;
    din = d;
    in_last = l;
  endtask
  task automatic gap();
    @(negedge clk);
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic expect_frame(input logic e, input logic [2:0] fw, input logic er);
    q.push_back(res_t'{e, fw, er});
  endtask
  task automatic wait_result(input bit hold);
    int n = 0;
    res_t r;
    do begin
      @(negedge clk);
      if (!hold) in_valid = 0;
      in_last = 0;
      n++;
    end while (!par_valid && n < 8);
    chk1("par_valid_strobe", par_valid, 1'b1);
    if (par_valid && q.size() > 0) begin
      r = q.pop_front();
      chk1("even", even, r.e);
      chk1("odd", odd, ~r.e);
      chk3("frame_words", frame_words, r.fw);
      chk1("in_ready_done", in_ready, 1'b0);
`ifdef PARITY_CHECK_EN
      chk1("err", err, r.er);
`endif
    end
    @(negedge clk);
    chk1("par_valid_drop", par_valid, 1'b0);
    chk1("in_ready_after", in_ready, 1'b1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    #2 chk_reset("reset");
    @(negedge clk) rst = 0;
    send(8'h01, 0); send(8'h03, 0); send(8'h00, 0); send(8'hFF, 0);
    expect_frame(1, 4, 0);
    wait_result(0);
    send(8'h01, 0); send(8'h01, 0); send(8'h01, 0); send(8'h01, 1);
    expect_frame(0, 4, 0);
    wait_result(0);
    send(8'h0F, 0); send(8'hF0, 1);
    expect_frame(0, 2, 0);
    wait_result(0);
    gap(); gap(); gap();
    chk1("hold_even", even, 1'b0);
    chk1("hold_odd", odd, 1'b1);
    chk3("hold_frame_words", frame_words, 3'd2);
    send(8'h80, 0); gap(); send(8'h00, 0); gap(); gap(); send(8'h00, 0); send(8'h00, 0);
    expect_frame(1, 4, 0);
    wait_result(1);
    send(8'h01, 1);
    expect_frame(1, 2, 0);
    wait_result(0);
    send(8'h01, 0); send(8'h01, 0);
    gap();
    #2 rst = 1;
    #1 chk_reset("async_reset");
    #1 rst = 0;
    send(8'h07, 1);
    expect_frame(1, 1, 0);
    wait_result(0);
`ifdef PARITY_CHECK_EN
    odd_sel = 0; exp_par = 0;
    send(8'h0F, 0); send(8'hF0, 1);
    expect_frame(0, 2, 0);
    wait_result(0);
    exp_par = 1;
    send(8'h0F, 0); send(8'hF0, 1);
    expect_frame(0, 2, 1);
    wait_result(0);
    odd_sel = 1;
    send(8'h0F, 0);
    odd_sel = 0;
    send(8'hF0, 1);
    expect_frame(0, 2, 0);
    wait_result(0);
`endif
    chk3("scoreboard_empty", 3'(q.size()), 3'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
